logic_gates_checker: RTL and testbench

- Self-checking stimulus/response engine for the two-input basic gate block: drives a/b, samples the seven gate outputs, compares against golden values.
- Sits on the opposite side of the gate block's interface. Its a_out/b_out feed the gate block's a/b; the gate block's seven outputs return on the *_in ports.
- Used for on-chip/bench self-test: one start pulse runs all four vectors and reports pass/fail plus first-failure diagnostics.

---
 rtl/logic_gates_checker.sv | 146 ++++++++++++++
 tb/tb_logic_gates_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_checker.sv
// Self-test engine for the two-input basic gate block. One start pulse walks
// the four {a,b} vectors in order 00, 01, 10, 11. For each vector it waits
// SETTLE_CYCLES, samples the seven gate outputs and compares them against
// golden values. It reports pass/fail, a saturating count of failing vectors,
// and the vector and mismatch mask of the first failure.
module logic_gates_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             not_in,
    input  logic             nand_in,
    input  logic             nor_in,
    input  logic             xor_in,
    input  logic             xnor_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask
);

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       expected;
    logic [6:0]       observed;
    logic [6:0]       mismatch;
    logic             cnt_last;

    assign busy     = (state != IDLE);
    assign cnt_last = (cnt == CNT_LAST);

    // Golden gate values for the vector currently under test, plus mismatch
    // bits. Bit order: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor.
    always_comb begin
        expected = {~(vec[1] ^ vec[0]), vec[1] ^ vec[0], ~(vec[1] | vec[0]),
                    ~(vec[1] & vec[0]), ~vec[1], vec[1] | vec[0], vec[1] & vec[0]};
        observed = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
        mismatch = observed ^ expected;
    end

    // State register.
    // NOTE: reset is asynchronous, so rst_n sits in the sensitivity list and
    // an aborted run is dropped at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one SETTLE/CHECK pair per vector, then DONE.
    always_comb begin
        // NOTE: next_state is given a default before the case statement so
        // every path assigns it and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SETTLE;
            SETTLE:  if (cnt_last) next_state = CHECK;
            CHECK:   next_state = (vec == 2'd3) ? DONE : SETTLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stimulus, settle counter, result collection and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            cnt       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below reads the
            // register values from before this edge (e.g. err_count in CHECK).
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        cnt       <= '0;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        fail_mask <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                end
                CHECK: begin
                    if (mismatch != 7'd0) begin
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        // A zero count means no earlier vector of this run failed.
                        if (err_count == '0) begin
                            fail_vec  <= vec;
                            fail_mask <= mismatch;
                        end
                    end
                    if (vec != 2'd3) begin
                        vec            <= vec + 2'd1;
                        {a_out, b_out} <= vec + 2'd1;
                        cnt            <= '0;
                    end
                end
                DONE: begin
                    pass  <= (err_count == '0);
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gates_checker.sv
// Bench for logic_gates_checker. Three checker instances (default, ERR_W=2,
// SETTLE_CYCLES=3) each face a behavioural gate block that can carry a fault.
// Expected run results are pushed to a scoreboard when start is driven and
// popped when done is seen.
module tb_logic_gates_checker;

    typedef struct {
        logic [2:0] err;
        logic [1:0] fvec;
        logic [6:0] fmask;
        logic       pass;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic [6:0] obs_v   [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       pass_v  [3];
    logic [2:0] err_v   [3];
    logic [1:0] err1;
    logic [1:0] fvec_v  [3];
    logic [6:0] fmask_v [3];
    logic       glitch_v[3];
    int         fault   [3];
    logic [7:0] rc      [3];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural gate block; bit order [0]and .. [6]xnor.
    function automatic logic [6:0] golden(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    // Fault modes: 0 none, 1 xor stuck at 0, 2 all outputs inverted,
    // 3 all outputs inverted while glitch is high.
    function automatic logic [6:0] gate_model(input logic a, input logic b,
                                              input int f, input logic glitch);
        logic [6:0] g;
        g = golden(a, b);
        if (f == 1) g[5] = 1'b0;
        if (f == 2 || (f == 3 && glitch)) g = ~g;
        return g;
    endfunction

    // Cycles since the run started; the first settle cycle of each vector
    // with SETTLE_CYCLES=3 is every fourth cycle, starting at 0.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rc[i] <= busy_v[i] ? rc[i] + 8'd1 : 8'd0;
    end

    for (genvar g = 0; g < 3; g++) begin : g_gate
        assign glitch_v[g] = busy_v[g] && (rc[g][1:0] == 2'd0);
        assign obs_v[g]    = gate_model(a_v[g], b_v[g], fault[g], glitch_v[g]);
    end

    assign err_v[1] = {1'b0, err1};

    logic_gates_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
        .and_in(obs_v[0][0]), .or_in(obs_v[0][1]), .not_in(obs_v[0][2]),
        .nand_in(obs_v[0][3]), .nor_in(obs_v[0][4]), .xor_in(obs_v[0][5]),
        .xnor_in(obs_v[0][6]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .fail_vec(fvec_v[0]), .fail_mask(fmask_v[0])
    );

    logic_gates_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
        .and_in(obs_v[1][0]), .or_in(obs_v[1][1]), .not_in(obs_v[1][2]),
        .nand_in(obs_v[1][3]), .nor_in(obs_v[1][4]), .xor_in(obs_v[1][5]),
        .xnor_in(obs_v[1][6]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err1), .fail_vec(fvec_v[1]), .fail_mask(fmask_v[1])
    );

    logic_gates_checker #(.SETTLE_CYCLES(3), .ERR_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
        .and_in(obs_v[2][0]), .or_in(obs_v[2][1]), .not_in(obs_v[2][2]),
        .nand_in(obs_v[2][3]), .nor_in(obs_v[2][4]), .xor_in(obs_v[2][5]),
        .xnor_in(obs_v[2][6]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .fail_vec(fvec_v[2]), .fail_mask(fmask_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result of one run: values seen at sample time are steady
    // (no glitch), compared against the golden gates for each vector.
    function automatic exp_t model(input int f, input int err_max, input int settle);
        exp_t       e;
        logic [6:0] mm;
        int         n = 0;
        e.fvec  = 2'd0;
        e.fmask = 7'd0;
        for (int v = 0; v < 4; v++) begin
            mm = gate_model(v[1], v[0], f, 1'b0) ^ golden(v[1], v[0]);
            if (mm != 7'd0) begin
                if (n == 0) begin
                    e.fvec  = v[1:0];
                    e.fmask = mm;
                end
                n++;
            end
        end
        e.err  = 3'((n > err_max) ? err_max : n);
        e.pass = (n == 0);
        e.lat  = 4 * (settle + 1) + 1;
        return e;
    endfunction

    // One complete run on instance idx; optional start re-pulses mid-run.
    task automatic do_run(input int idx, input int f, input int err_max,
                          input int settle, input bit repulse);
        exp_t e;
        int   k        = 0;
        int   busy_cnt = 0;
        int   n_done   = 0;
        bit   got_done = 0;
        fault[idx] = f;
        sb.push_back(model(f, err_max, settle));
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        while (!got_done && k < 200) begin
            @(negedge clk);
            start_v[idx] = repulse && (k == 3 || k == 5);
            if (done_v[idx]) begin
                got_done = 1;
            end else begin
                if (busy_v[idx]) busy_cnt++;
                k++;
            end
        end
        start_v[idx] = 1'b0;
        check($sformatf("done_seen[%0d]", idx), 32'(got_done), 32'd1);
        e = sb.pop_front();
        check($sformatf("latency[%0d]", idx), k, e.lat);
        check($sformatf("busy_cycles[%0d]", idx), busy_cnt, e.lat);
        check($sformatf("err_count[%0d]", idx), 32'(err_v[idx]), 32'(e.err));
        check($sformatf("fail_vec[%0d]", idx), 32'(fvec_v[idx]), 32'(e.fvec));
        check($sformatf("fail_mask[%0d]", idx), 32'(fmask_v[idx]), 32'(e.fmask));
        check($sformatf("pass[%0d]", idx), 32'(pass_v[idx]), 32'(e.pass));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_v[idx]) n_done++;
        end
        check($sformatf("done_single_pulse[%0d]", idx), n_done, 0);
        check($sformatf("hold_results[%0d]", idx),
              {err_v[idx], fvec_v[idx], fmask_v[idx], pass_v[idx], busy_v[idx]},
              {e.err, e.fvec, e.fmask, e.pass, 1'b0});
    endtask

    initial begin
        int n_done;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            fault[i]   = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_state[%0d]", i),
                  {a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], fvec_v[i], fmask_v[i]},
                  32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_run(0, 0, 7, 1, 1'b0);  // correct gate block
        do_run(0, 1, 7, 1, 1'b0);  // xor stuck at 0
        do_run(0, 1, 7, 1, 1'b1);  // same, start re-pulsed mid-run
        do_run(1, 2, 3, 1, 1'b0);  // all inverted, 2-bit counter saturates
        do_run(2, 3, 7, 3, 1'b0);  // long settle, first-cycle glitch ignored

        // Reset in cycle 4 of a run (vector 10 is on the stimulus outputs).
        fault[0] = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_state", {busy_v[0], a_v[0], b_v[0]}, 32'b110);
        rst_n = 1'b0;
        #1;
        check("reset_mid_run",
              {a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fvec_v[0], fmask_v[0]},
              32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_v[0]) n_done++;
        end
        check("no_done_after_abort", n_done, 0);
        do_run(0, 0, 7, 1, 1'b0);  // normal run after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
